alu_share_arbiter: RTL

Shares one combinational 32-bit ALU between NREQ requesters (e.g. EX stage, branch-target unit, address generator). Per-requester valid/ready request channels; round-robin grant; ALU result captured in an output register and returned on one tagged response channel with valid/ready backpressure. Sits beside the ALU in the pipeline datapath and drives its SrcA/SrcB/control inputs.

---
 rtl/alu_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/alu_share_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ALU control encodings and datapath width shared by the ALU arbiter slice.
package alu_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// grant asserted only when en is high.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [IDW:0] pos;

  assign any = |req;

  // scan high-to-low so the entry closest to ptr is written last
  always_comb begin
    idx = '0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDW + 1)'(k);
      if (pos >= (IDW + 1)'(NREQ))
        pos = pos - (IDW + 1)'(NREQ);
      if (req[pos[IDW-1:0]])
        idx = pos[IDW-1:0];
    end
  end

  always_comb begin
    grant = '0;
    if (en && any)
      grant[idx] = 1'b1;
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NREQ requesters with a registered, tagged response.
// Define ALU_ARB_PERF_EN to build the grant/stall performance counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*3-1:0]    req_ctrl,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [XLEN-1:0]      alu_res,
  input  logic                 alu_zero,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic                 resp_zero,
  output logic [IDW-1:0]       resp_id,
  output logic [NREQ*XLEN-1:0] grant_cnt,
  output logic [XLEN-1:0]      stall_cnt
);
  logic            can_issue;
  logic            accept;
  logic            any;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] grant;

  // output register drains in the same cycle it refills
  assign can_issue = !resp_valid || resp_ready;
  assign accept    = can_issue && any;
  assign req_ready = grant;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (can_issue),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign alu_a    = accept ? req_a[XLEN*win +: XLEN] : '0;
  assign alu_b    = accept ? req_b[XLEN*win +: XLEN] : '0;
  assign alu_ctrl = accept ? req_ctrl[3*win +: 3] : 3'b000;

  assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_id    <= '0;
      ptr        <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= alu_res;
      resp_zero  <= alu_zero;
      resp_id    <= win;
      ptr        <= ptr_next;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_gcnt
    logic [XLEN-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt <= '0;
      else if (grant[i] && cnt != '1)
        cnt <= cnt + 1'b1;
    end
    assign grant_cnt[XLEN*i +: XLEN] = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (any && !can_issue && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule
